// File: rtl/dm_store.sv
// dm_store: MEM-stage data memory for the pipelined MIPS core.
//   Byte-enable stores (sw/sh/sb) into a 2^DEPTH_LOG2 x 32 array with a
//   synchronous read-first word read. The read word, the low address bits
//   and the load opcode are registered into the WB stage, where they feed
//   the load-extension unit.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high; clears the array and output registers
//   A          byte address from the ALU
//   WD         store data
//   MemWrite   store enable
//   StoreOp    00 sw, 01 sh, 10 sb, 11 no write
//   LoadOpIn   load-extension opcode of the MEM-stage instruction
//   RD         registered memory word (WB stage)
//   ALo        registered A[1:0]
//   LoadOp     registered LoadOpIn
module dm_store #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] WD,
   input  logic        MemWrite,
   input  logic [1:0]  StoreOp,
   input  logic [2:0]  LoadOpIn,
   output logic [31:0] RD,
   output logic [1:0]  ALo,
   output logic [2:0]  LoadOp
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   logic [31:0]           mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] idx;
   logic [3:0]            be;
   logic [31:0]           wdata;
   logic [31:0]           rd_d, rd_q;
   logic [1:0]            alo_d, alo_q;
   logic [2:0]            load_op_d, load_op_q;

   // Upper address bits are intentionally dropped: the address wraps.
   logic unused_addr_bits;
   assign unused_addr_bits = ^A[31:DEPTH_LOG2+2];

   assign idx = A[DEPTH_LOG2+1:2];

   // Sub-word data is replicated across all lanes so each enabled lane
   // simply takes its own byte slice of wdata.
   always_comb begin
      be    = 4'b0000;
      wdata = WD;
      if (MemWrite) begin
         unique case (StoreOp)
            2'b00: be = 4'b1111;
            2'b01: begin
               be    = A[1] ? 4'b1100 : 4'b0011;
               wdata = {2{WD[15:0]}};
            end
            2'b10: begin
               be    = 4'b0001 << A[1:0];
               wdata = {4{WD[7:0]}};
            end
            default: be = 4'b0000;
         endcase
      end
   end

   always_comb begin
      rd_d      = mem_q[idx];
      alo_d     = A[1:0];
      load_op_d = LoadOpIn;
   end

   // Whole-array clear in one edge, so the array lives in flops rather than
   // an inferred RAM macro.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 32'h0;
         end
         rd_q      <= 32'h0;
         alo_q     <= 2'b00;
         load_op_q <= 3'b000;
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
         end
         rd_q      <= rd_d;
         alo_q     <= alo_d;
         load_op_q <= load_op_d;
      end
   end

   assign RD     = rd_q;
   assign ALo    = alo_q;
   assign LoadOp = load_op_q;

endmodule

// File: tb/tb_dm_store.sv
module tb_dm_store;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] WD;
   logic        MemWrite;
   logic [1:0]  StoreOp;
   logic [2:0]  LoadOpIn;
   logic [31:0] RD;
   logic [1:0]  ALo;
   logic [2:0]  LoadOp;

   int n_checks;
   int n_fails;

   dm_store #(.DEPTH_LOG2(10)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .A        (A),
      .WD       (WD),
      .MemWrite (MemWrite),
      .StoreOp  (StoreOp),
      .LoadOpIn (LoadOpIn),
      .RD       (RD),
      .ALo      (ALo),
      .LoadOp   (LoadOp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One clock; outputs sampled 1 time unit after the edge.
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
      A = addr; WD = data; StoreOp = op; MemWrite = 1'b1; LoadOpIn = 3'b000;
      cyc();
      MemWrite = 1'b0;
   endtask

   task automatic load(input logic [31:0] addr, input logic [2:0] lop);
      A = addr; LoadOpIn = lop; MemWrite = 1'b0; StoreOp = 2'b00;
      cyc();
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      reset = 1'b1; A = 32'h0; WD = 32'h0; MemWrite = 1'b0; StoreOp = 2'b00; LoadOpIn = 3'b000;
      cyc();
      chk("reset_rd", RD, 32'h0);
      chk("reset_alo", {30'h0, ALo}, 32'h0);
      chk("reset_lop", {29'h0, LoadOp}, 32'h0);
      reset = 1'b0;

      load(32'h0000_0010, 3'b000);
      chk("post_reset_rd", RD, 32'h0);
      chk("post_reset_alo", {30'h0, ALo}, 32'h0);

      store(2'b00, 32'h0000_0004, 32'h1234_5678);
      load(32'h0000_0007, 3'b000);
      chk("sw_lw_rd", RD, 32'h1234_5678);
      chk("sw_lw_alo", {30'h0, ALo}, 32'h3);

      store(2'b00, 32'h0000_0008, 32'hAAAA_AAAA);
      store(2'b01, 32'h0000_000A, 32'hFFFF_BEEF);
      load(32'h0000_0008, 3'b011);
      chk("sh_hi_rd", RD, 32'hBEEF_AAAA);
      chk("sh_hi_lop", {29'h0, LoadOp}, 32'h3);
      store(2'b01, 32'h0000_0008, 32'h0000_1234);
      load(32'h0000_0008, 3'b000);
      chk("sh_lo_rd", RD, 32'hBEEF_1234);

      store(2'b00, 32'h0000_000C, 32'h0);
      store(2'b10, 32'h0000_000C, 32'hFFFF_FF11);
      store(2'b10, 32'h0000_000D, 32'hFFFF_FF22);
      store(2'b10, 32'h0000_000E, 32'hFFFF_FF33);
      store(2'b10, 32'h0000_000F, 32'hFFFF_FF44);
      load(32'h0000_000F, 3'b010);
      chk("sb_rd", RD, 32'h4433_2211);
      chk("sb_alo", {30'h0, ALo}, 32'h3);
      chk("sb_lop", {29'h0, LoadOp}, 32'h2);

      store(2'b00, 32'h0000_0010, 32'h1);
      store(2'b00, 32'h0000_0010, 32'h2);
      chk("rw_same_old", RD, 32'h1);
      load(32'h0000_0010, 3'b000);
      chk("rw_same_new", RD, 32'h2);

      store(2'b00, 32'h0000_1000, 32'hDEAD_BEEF);
      load(32'h0000_0000, 3'b000);
      chk("wrap_rd", RD, 32'hDEAD_BEEF);

      reset = 1'b1; LoadOpIn = 3'b100;
      A = 32'h0000_0023; WD = 32'hCAFE_0000; StoreOp = 2'b00; MemWrite = 1'b1;
      cyc();
      reset = 1'b0; MemWrite = 1'b0;
      chk("rst_mid_rd", RD, 32'h0);
      chk("rst_mid_alo", {30'h0, ALo}, 32'h0);
      chk("rst_mid_lop", {29'h0, LoadOp}, 32'h0);
      load(32'h0000_0020, 3'b000);
      chk("rst_discard_wr", RD, 32'h0);
      load(32'h0000_0004, 3'b000);
      chk("rst_clear_array", RD, 32'h0);

      store(2'b00, 32'h0000_0024, 32'h0000_0055);
      store(2'b11, 32'h0000_0024, 32'hFFFF_FFFF);
      load(32'h0000_0024, 3'b000);
      chk("op11_nowrite", RD, 32'h0000_0055);
      A = 32'h0000_0024; WD = 32'hFFFF_FFFF; StoreOp = 2'b00; MemWrite = 1'b0;
      cyc();
      load(32'h0000_0024, 3'b001);
      chk("mw0_nowrite", RD, 32'h0000_0055);
      chk("lbu_lop", {29'h0, LoadOp}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
